// File: rtl/iob_pkg.sv
// iob_pkg: shared types and constants for the iob_bridge core-to-AXI-lite bridge.
//   iob_state_e    : bridge FSM state encoding
//   TAG_W          : width of the core data-request tag
//   AXI_RESP_*     : AXI response codes
//   resp_is_err()  : any non-OKAY response is reported to the core as an error
package iob_pkg;

    localparam int TAG_W = 11;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4,
        S_RESP    = 3'd5
    } iob_state_e;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/iob_arbiter.sv
// iob_arbiter: IDLE-state grant logic for the two core request ports.
//   idle_i             : bridge FSM is in IDLE (no transaction outstanding)
//   d_ren_i, d_wen_i   : core data read enable / byte write strobes
//   i_ren_i            : core fetch read enable
//   d_accept_o         : data request accepted this cycle
//   i_accept_o         : fetch request accepted this cycle
//   d_write_o          : accepted data request is a write (strobes win over ren)
module iob_arbiter (
    input  logic       idle_i,
    input  logic       d_ren_i,
    input  logic [3:0] d_wen_i,
    input  logic       i_ren_i,
    output logic       d_accept_o,
    output logic       i_accept_o,
    output logic       d_write_o
);

    logic d_req;

    // Data always wins a tie; a losing fetch simply stays pending in IDLE.
    assign d_req      = d_ren_i | (|d_wen_i);
    assign d_accept_o = idle_i & d_req;
    assign i_accept_o = idle_i & i_ren_i & ~d_req;
    assign d_write_o  = |d_wen_i;

endmodule

// File: rtl/iob_bridge.sv
// iob_bridge: bridges the core data port and fetch port onto a single AXI-lite
// master with at most one transaction outstanding.
//   clk, rst_n          : clock, synchronous active-low reset
//   core__d_*           : data request in; d__core_* data response out
//   core__i_*           : fetch request in; i__core_* fetch response out
//   mio__axi_*          : AXI-lite master (AR/R, AW/W/B)
// Optional build macro IOB_TIMEOUT_EN: abort a stalled bus transaction after
// TIMEOUT_CYCLES busy cycles and answer the core with an error.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | no transaction; requests accepted combinationally
// RD_ADDR   | arvalid held until arready
// RD_DATA   | rready held until rvalid
// WR_REQ    | awvalid/wvalid, each dropped on its own ready
// WR_RESP   | bready held until bvalid
// RESP      | one-cycle val pulse to the requesting port
module iob_bridge
    import iob_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      core__d_addr,
    input  logic [31:0]      core__d_wdata,
    input  logic             core__d_ren,
    input  logic [3:0]       core__d_wen,
    input  logic [TAG_W-1:0] core__d_req_tag,
    output logic             d__core_accept,
    output logic             d__core_val,
    output logic             d__core_error,
    output logic [31:0]      d__core_rdata,
    output logic [TAG_W-1:0] d__core_resp_tag,
    input  logic [31:0]      core__i_addr,
    input  logic             core__i_ren,
    output logic             i__core_accept,
    output logic             i__core_val,
    output logic             i__core_error,
    output logic [31:0]      i__core_rdata,
    output logic [31:0]      i__core_pc,
    output logic             mio__axi_arvalid,
    output logic [31:0]      mio__axi_araddr,
    input  logic             mio__axi_arready,
    output logic             mio__axi_awvalid,
    output logic [31:0]      mio__axi_awaddr,
    input  logic             mio__axi_awready,
    output logic             mio__axi_wvalid,
    output logic [31:0]      mio__axi_wdata,
    output logic [3:0]       mio__axi_wstrb,
    input  logic             mio__axi_wready,
    input  logic             mio__axi_bvalid,
    input  logic [1:0]       mio__axi_bresp,
    output logic             mio__axi_bready,
    input  logic             mio__axi_rvalid,
    input  logic [31:0]      mio__axi_rdata,
    input  logic [1:0]       mio__axi_rresp,
    output logic             mio__axi_rready
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("iob_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    iob_state_e       state_q, state_d;
    logic [31:0]      addr_q, wdata_q;
    logic [3:0]       wen_q;
    logic [TAG_W-1:0] tag_q, rsp_tag_q;
    logic             src_fetch_q;
    logic             aw_done_q, w_done_q;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d, rsp_pc_q;
    logic             rsp_err_q, rsp_err_d, rsp_load;

    logic d_accept, i_accept, d_write, start;
    logic busy, rd_hs, wr_hs, aw_ok, w_ok, timeout_hit;

    iob_arbiter u_arbiter (
        .idle_i     (state_q == S_IDLE),
        .d_ren_i    (core__d_ren),
        .d_wen_i    (core__d_wen),
        .i_ren_i    (core__i_ren),
        .d_accept_o (d_accept),
        .i_accept_o (i_accept),
        .d_write_o  (d_write)
    );

    assign start = d_accept | i_accept;
    assign busy  = (state_q == S_RD_ADDR) || (state_q == S_RD_DATA) ||
                   (state_q == S_WR_REQ)  || (state_q == S_WR_RESP);
    assign rd_hs = (state_q == S_RD_DATA) && mio__axi_rvalid;
    assign wr_hs = (state_q == S_WR_RESP) && mio__axi_bvalid;
    assign aw_ok = aw_done_q | mio__axi_awready;
    assign w_ok  = w_done_q  | mio__axi_wready;

`ifdef IOB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Down-counter loaded at accept; terminal count on the last allowed busy cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = CNT_W'(TIMEOUT_CYCLES - 1);
        end else if (busy && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit = busy && (cnt_q == '0);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (d_accept) begin
                    state_d = d_write ? S_WR_REQ : S_RD_ADDR;
                end else if (i_accept) begin
                    state_d = S_RD_ADDR;
                end
            end
            S_RD_ADDR: if (mio__axi_arready) state_d = S_RD_DATA;
            S_RD_DATA: if (mio__axi_rvalid)  state_d = S_RESP;
            S_WR_REQ:  if (aw_ok && w_ok)    state_d = S_WR_RESP;
            S_WR_RESP: if (mio__axi_bvalid)  state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (timeout_hit) begin
            state_d = S_RESP;
        end
    end

    always_comb begin
        mio__axi_arvalid = (state_q == S_RD_ADDR);
        mio__axi_rready  = (state_q == S_RD_DATA);
        mio__axi_awvalid = (state_q == S_WR_REQ) && !aw_done_q;
        mio__axi_wvalid  = (state_q == S_WR_REQ) && !w_done_q;
        mio__axi_bready  = (state_q == S_WR_RESP);
        d__core_val      = (state_q == S_RESP) && !src_fetch_q;
        i__core_val      = (state_q == S_RESP) && src_fetch_q;
    end

    // A real bus handshake outranks a timeout landing on the same cycle.
    always_comb begin
        rsp_load    = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (rd_hs) begin
            rsp_load    = 1'b1;
            rsp_rdata_d = mio__axi_rdata;
            rsp_err_d   = resp_is_err(mio__axi_rresp);
        end else if (wr_hs) begin
            rsp_load    = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = resp_is_err(mio__axi_bresp);
        end else if (timeout_hit) begin
            rsp_load    = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wen_q       <= '0;
            tag_q       <= '0;
            src_fetch_q <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_pc_q    <= '0;
        end else begin
            if (start) begin
                // Fetches are always word aligned on the bus.
                addr_q      <= d_accept ? core__d_addr : (core__i_addr & ~32'h3);
                wdata_q     <= core__d_wdata;
                wen_q       <= d_accept ? core__d_wen : 4'b0000;
                tag_q       <= core__d_req_tag;
                src_fetch_q <= ~d_accept;
                aw_done_q   <= 1'b0;
                w_done_q    <= 1'b0;
            end
            if (state_q == S_WR_REQ) begin
                aw_done_q <= aw_ok;
                w_done_q  <= w_ok;
            end
            if (rsp_load) begin
                rsp_rdata_q <= rsp_rdata_d;
                rsp_err_q   <= rsp_err_d;
                if (src_fetch_q) begin
                    rsp_pc_q <= addr_q;
                end else begin
                    rsp_tag_q <= tag_q;
                end
            end
        end
    end

    assign d__core_accept   = d_accept;
    assign i__core_accept   = i_accept;
    assign d__core_rdata    = rsp_rdata_q;
    assign d__core_error    = rsp_err_q;
    assign d__core_resp_tag = rsp_tag_q;
    assign i__core_rdata    = rsp_rdata_q;
    assign i__core_error    = rsp_err_q;
    assign i__core_pc       = rsp_pc_q;
    assign mio__axi_araddr  = addr_q;
    assign mio__axi_awaddr  = addr_q;
    assign mio__axi_wdata   = wdata_q;
    assign mio__axi_wstrb   = wen_q;

endmodule

// File: tb/tb_iob_bridge.sv
// tb_iob_bridge: directed self-checking bench for iob_bridge. Inputs are driven
// and outputs sampled on the falling edge; the AXI slave is played by tasks.
// Build with +define+IOB_TIMEOUT_EN to include the bus-timeout scenario.
module tb_iob_bridge;
    import iob_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      core__d_addr, core__d_wdata, core__i_addr;
    logic             core__d_ren, core__i_ren;
    logic [3:0]       core__d_wen;
    logic [TAG_W-1:0] core__d_req_tag;
    logic             d__core_accept, d__core_val, d__core_error;
    logic [31:0]      d__core_rdata;
    logic [TAG_W-1:0] d__core_resp_tag;
    logic             i__core_accept, i__core_val, i__core_error;
    logic [31:0]      i__core_rdata, i__core_pc;
    logic             mio__axi_arvalid, mio__axi_arready;
    logic [31:0]      mio__axi_araddr;
    logic             mio__axi_awvalid, mio__axi_awready;
    logic [31:0]      mio__axi_awaddr;
    logic             mio__axi_wvalid, mio__axi_wready;
    logic [31:0]      mio__axi_wdata;
    logic [3:0]       mio__axi_wstrb;
    logic             mio__axi_bvalid, mio__axi_bready;
    logic [1:0]       mio__axi_bresp;
    logic             mio__axi_rvalid, mio__axi_rready;
    logic [31:0]      mio__axi_rdata;
    logic [1:0]       mio__axi_rresp;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0;
    logic seen;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iob_bridge #(.TIMEOUT_CYCLES(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .core__d_addr(core__d_addr), .core__d_wdata(core__d_wdata),
        .core__d_ren(core__d_ren), .core__d_wen(core__d_wen),
        .core__d_req_tag(core__d_req_tag),
        .d__core_accept(d__core_accept), .d__core_val(d__core_val),
        .d__core_error(d__core_error), .d__core_rdata(d__core_rdata),
        .d__core_resp_tag(d__core_resp_tag),
        .core__i_addr(core__i_addr), .core__i_ren(core__i_ren),
        .i__core_accept(i__core_accept), .i__core_val(i__core_val),
        .i__core_error(i__core_error), .i__core_rdata(i__core_rdata),
        .i__core_pc(i__core_pc),
        .mio__axi_arvalid(mio__axi_arvalid), .mio__axi_araddr(mio__axi_araddr),
        .mio__axi_arready(mio__axi_arready),
        .mio__axi_awvalid(mio__axi_awvalid), .mio__axi_awaddr(mio__axi_awaddr),
        .mio__axi_awready(mio__axi_awready),
        .mio__axi_wvalid(mio__axi_wvalid), .mio__axi_wdata(mio__axi_wdata),
        .mio__axi_wstrb(mio__axi_wstrb), .mio__axi_wready(mio__axi_wready),
        .mio__axi_bvalid(mio__axi_bvalid), .mio__axi_bresp(mio__axi_bresp),
        .mio__axi_bready(mio__axi_bready),
        .mio__axi_rvalid(mio__axi_rvalid), .mio__axi_rdata(mio__axi_rdata),
        .mio__axi_rresp(mio__axi_rresp), .mio__axi_rready(mio__axi_rready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        core__d_addr = '0; core__d_wdata = '0; core__d_ren = 1'b0;
        core__d_wen = '0; core__d_req_tag = '0;
        core__i_addr = '0; core__i_ren = 1'b0;
        mio__axi_arready = 1'b0; mio__axi_awready = 1'b0; mio__axi_wready = 1'b0;
        mio__axi_bvalid = 1'b0; mio__axi_bresp = '0;
        mio__axi_rvalid = 1'b0; mio__axi_rdata = '0; mio__axi_rresp = '0;
    endtask

    // Called at a falling edge; returns at the falling edge after the AR handshake.
    task automatic ar_phase(input logic [31:0] exp_addr);
        int n = 0;
        while (!mio__axi_arvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("arvalid_seen", 32'(mio__axi_arvalid), 32'd1);
        check("araddr", mio__axi_araddr, exp_addr);
        mio__axi_arready = 1'b1;
        @(negedge clk);
        mio__axi_arready = 1'b0;
    endtask

    // Returns at the falling edge of the RESP cycle.
    task automatic r_phase(input logic [31:0] rd, input logic [1:0] rr);
        int n = 0;
        while (!mio__axi_rready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rready_seen", 32'(mio__axi_rready), 32'd1);
        mio__axi_rvalid = 1'b1; mio__axi_rdata = rd; mio__axi_rresp = rr;
        @(negedge clk);
        mio__axi_rvalid = 1'b0; mio__axi_rdata = '0; mio__axi_rresp = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_arvalid", 32'(mio__axi_arvalid), 32'd0);
        check("rst_awvalid", 32'(mio__axi_awvalid), 32'd0);
        check("rst_wvalid",  32'(mio__axi_wvalid),  32'd0);
        check("rst_bready",  32'(mio__axi_bready),  32'd0);
        check("rst_rready",  32'(mio__axi_rready),  32'd0);
        check("rst_vals",    32'({d__core_val, i__core_val}), 32'd0);
        check("rst_rdata",   d__core_rdata, 32'd0);
        check("rst_tag",     32'(d__core_resp_tag), 32'd0);
        check("rst_pc",      i__core_pc, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fetch of 0x6: bus address word aligned, val 3 cycles after accept
        core__i_addr = 32'h6; core__i_ren = 1'b1;
        #1;
        check("f_i_accept", 32'(i__core_accept), 32'd1);
        check("f_d_accept", 32'(d__core_accept), 32'd0);
        t0 = cyc;
        @(negedge clk);
        core__i_ren = 1'b0; core__i_addr = '0;
        ar_phase(32'h4);
        r_phase(32'h13, AXI_RESP_OKAY);
        check("f_i_val",   32'(i__core_val), 32'd1);
        check("f_latency", cyc - t0, 32'd3);
        check("f_rdata",   i__core_rdata, 32'h13);
        check("f_pc",      i__core_pc, 32'h4);
        check("f_error",   32'(i__core_error), 32'd0);
        check("f_d_val",   32'(d__core_val), 32'd0);
        @(negedge clk);
        check("f_val_pulse", 32'(i__core_val), 32'd0);
        check("f_rdata_hold", i__core_rdata, 32'h13);

        // Data write, awready two cycles after wready
        core__d_addr = 32'h9200_0000; core__d_wdata = 32'hA5;
        core__d_wen = 4'b0001; core__d_req_tag = 11'h155;
        #1;
        check("w_d_accept", 32'(d__core_accept), 32'd1);
        @(negedge clk);
        core__d_wen = '0; core__d_addr = '0; core__d_wdata = '0; core__d_req_tag = '0;
        check("w_awvalid", 32'(mio__axi_awvalid), 32'd1);
        check("w_wvalid",  32'(mio__axi_wvalid),  32'd1);
        check("w_awaddr",  mio__axi_awaddr, 32'h9200_0000);
        check("w_wdata",   mio__axi_wdata, 32'hA5);
        check("w_wstrb",   32'(mio__axi_wstrb), 32'd1);
        mio__axi_wready = 1'b1;
        @(negedge clk);
        mio__axi_wready = 1'b0;
        check("w_wvalid_drop", 32'(mio__axi_wvalid), 32'd0);
        check("w_awvalid_hold", 32'(mio__axi_awvalid), 32'd1);
        @(negedge clk);
        check("w_no_bready", 32'(mio__axi_bready), 32'd0);
        mio__axi_awready = 1'b1;
        @(negedge clk);
        mio__axi_awready = 1'b0;
        check("w_awvalid_drop", 32'(mio__axi_awvalid), 32'd0);
        check("w_bready", 32'(mio__axi_bready), 32'd1);
        mio__axi_bvalid = 1'b1; mio__axi_bresp = AXI_RESP_OKAY;
        @(negedge clk);
        mio__axi_bvalid = 1'b0;
        check("w_d_val", 32'(d__core_val), 32'd1);
        check("w_i_val", 32'(i__core_val), 32'd0);
        check("w_tag",   32'(d__core_resp_tag), 32'h155);
        check("w_rdata", d__core_rdata, 32'd0);
        check("w_error", 32'(d__core_error), 32'd0);
        @(negedge clk);
        check("w_val_pulse", 32'(d__core_val), 32'd0);

        // Simultaneous data read and fetch: data first, fetch waits for IDLE
        core__d_ren = 1'b1; core__d_addr = 32'h1000; core__d_req_tag = 11'h7;
        core__i_ren = 1'b1; core__i_addr = 32'h2003;
        #1;
        check("s_d_accept", 32'(d__core_accept), 32'd1);
        check("s_i_accept", 32'(i__core_accept), 32'd0);
        @(negedge clk);
        core__d_ren = 1'b0; core__d_addr = '0; core__d_req_tag = '0;
        #1;
        check("s_i_accept_busy", 32'(i__core_accept), 32'd0);
        ar_phase(32'h1000);
        r_phase(32'hDEAD_BEEF, AXI_RESP_OKAY);
        check("s_d_val",   32'(d__core_val), 32'd1);
        check("s_d_rdata", d__core_rdata, 32'hDEAD_BEEF);
        check("s_d_tag",   32'(d__core_resp_tag), 32'h7);
        check("s_i_accept_resp", 32'(i__core_accept), 32'd0);
        @(negedge clk);
        #1;
        check("s_i_accept_idle", 32'(i__core_accept), 32'd1);
        @(negedge clk);
        core__i_ren = 1'b0; core__i_addr = '0;
        ar_phase(32'h2000);
        r_phase(32'hCAFE_0001, AXI_RESP_OKAY);
        check("s_i_val",   32'(i__core_val), 32'd1);
        check("s_i_rdata", i__core_rdata, 32'hCAFE_0001);
        check("s_i_pc",    i__core_pc, 32'h2000);
        check("s_tag_hold", 32'(d__core_resp_tag), 32'h7);
        @(negedge clk);

        // Read with SLVERR
        core__d_ren = 1'b1; core__d_addr = 32'h3000; core__d_req_tag = 11'h3C;
        @(negedge clk);
        core__d_ren = 1'b0; core__d_addr = '0; core__d_req_tag = '0;
        ar_phase(32'h3000);
        r_phase(32'h5555_5555, AXI_RESP_SLVERR);
        check("e_d_val", 32'(d__core_val), 32'd1);
        check("e_error", 32'(d__core_error), 32'd1);
        check("e_tag",   32'(d__core_resp_tag), 32'h3C);
        @(negedge clk);

`ifdef IOB_TIMEOUT_EN
        // arready never comes: error response after 256 busy cycles
        core__d_ren = 1'b1; core__d_addr = 32'h4000;
        t0 = cyc;
        @(negedge clk);
        core__d_ren = 1'b0; core__d_addr = '0;
        for (int n = 0; n < 400 && !d__core_val; n++) @(negedge clk);
        check("t_d_val",   32'(d__core_val), 32'd1);
        check("t_latency", cyc - t0, 32'd257);
        check("t_error",   32'(d__core_error), 32'd1);
        check("t_rdata",   d__core_rdata, 32'd0);
        check("t_arvalid", 32'(mio__axi_arvalid), 32'd0);
        @(negedge clk);
`endif

        // Reset while in RD_DATA: transaction abandoned, no val
        core__d_ren = 1'b1; core__d_addr = 32'h5000; core__d_req_tag = 11'h2A;
        @(negedge clk);
        core__d_ren = 1'b0; core__d_addr = '0; core__d_req_tag = '0;
        ar_phase(32'h5000);
        check("r_rready_pre", 32'(mio__axi_rready), 32'd1);
        rst_n = 1'b0;
        mio__axi_rvalid = 1'b1; mio__axi_rdata = 32'h1234_5678; mio__axi_rresp = AXI_RESP_DECERR;
        @(negedge clk);
        check("r_arvalid", 32'(mio__axi_arvalid), 32'd0);
        check("r_rready",  32'(mio__axi_rready),  32'd0);
        check("r_val",     32'({d__core_val, i__core_val}), 32'd0);
        check("r_rdata",   d__core_rdata, 32'd0);
        check("r_error",   32'(d__core_error), 32'd0);
        check("r_tag",     32'(d__core_resp_tag), 32'd0);
        rst_n = 1'b1;
        mio__axi_rvalid = 1'b0; mio__axi_rdata = '0; mio__axi_rresp = '0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | d__core_val | i__core_val;
        end
        check("r_no_val", 32'(seen), 32'd0);
        core__d_ren = 1'b1;
        #1;
        check("r_idle_accept", 32'(d__core_accept), 32'd1);
        core__d_ren = 1'b0;
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iob_bridge.md
IOB_BRIDGE -- requirements
Module: iob_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256: bus-timeout limit, used only when IOB_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have core data-request inputs: core__d_addr (32 bits), core__d_wdata (32), core__d_ren (1), core__d_wen (4, byte strobes), core__d_req_tag (11).
REQ-005 SHALL have core data-response outputs: d__core_accept (1), d__core_val (1), d__core_error (1), d__core_rdata (32), d__core_resp_tag (11).
REQ-006 SHALL have core fetch inputs: core__i_addr (32) and core__i_ren (1).
REQ-007 SHALL have core fetch outputs: i__core_accept (1), i__core_val (1), i__core_error (1), i__core_rdata (32), i__core_pc (32).
REQ-008 SHALL have AXI-lite read-address ports: mio__axi_arvalid (out, 1), mio__axi_araddr (out, 32), mio__axi_arready (in, 1).
REQ-009 SHALL have AXI-lite write-address and write-data ports: mio__axi_awvalid (out, 1), mio__axi_awaddr (out, 32), mio__axi_awready (in, 1), mio__axi_wvalid (out, 1), mio__axi_wdata (out, 32), mio__axi_wstrb (out, 4), mio__axi_wready (in, 1).
REQ-010 SHALL have AXI-lite response ports: mio__axi_bvalid (in, 1), mio__axi_bresp (in, 2), mio__axi_bready (out, 1), mio__axi_rvalid (in, 1), mio__axi_rdata (in, 32), mio__axi_rresp (in, 2), mio__axi_rready (out, 1).

Function
REQ-011 SHALL bridge both core ports onto one AXI-lite master, with at most one transaction outstanding.
REQ-012 SHALL implement states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP and RESP.
REQ-013 SHALL, in IDLE, assert combinationally d__core_accept = (core__d_ren or core__d_wen != 0) and i__core_accept = core__i_ren and not data-request; all accepts SHALL be 0 outside IDLE.
REQ-014 SHALL give data priority over fetch on a simultaneous request; an unaccepted fetch SHALL wait in IDLE.
REQ-015 SHALL, on an accepted request, capture address, wdata, wen, tag and port source.
REQ-016 SHALL, on a read (core__d_ren, or any fetch), transition to RD_ADDR; fetch addresses SHALL be issued with bits [1:0] forced to 0.
REQ-017 SHALL, on a data write (wen != 0), transition to WR_REQ; wen takes precedence if ren and wen are both set.
REQ-018 SHALL, in RD_ADDR, hold arvalid=1 until arready; then enter RD_DATA with rready=1 until rvalid.
REQ-019 SHALL, in WR_REQ, assert awvalid and wvalid together and drop each independently on its own ready; WR_RESP (bready=1) SHALL be entered only after both handshakes complete.
REQ-020 SHALL register rdata/rresp or bresp into RESP; the cycle after the R/B handshake, exactly one of d__core_val or i__core_val SHALL pulse for one cycle, then the FSM SHALL return to IDLE.
REQ-021 SHALL set error = (resp != 2'b00); write responses SHALL return rdata=0.
REQ-022 SHALL drive d__core_resp_tag = captured tag and i__core_pc = captured fetch address.
REQ-023 SHALL hold the rdata/error/tag/pc outputs until the next response.
REQ-024 SHALL give a minimum read latency of 3 cycles from accept to val, with zero-wait slaves.

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, set the state to IDLE and drive all AXI valid/ready outputs, val, error, rdata, tag and pc to 0.
REQ-026 SHALL abandon any in-flight transaction on reset without a response to the core.

Configuration
REQ-027 SHALL, with IOB_TIMEOUT_EN defined, count cycles spent in RD_ADDR/RD_DATA/WR_REQ/WR_RESP; on reaching TIMEOUT_CYCLES it SHALL drop all AXI valids/readies, respond with error=1 and rdata=0, and return to IDLE.
REQ-028 SHALL, without IOB_TIMEOUT_EN, contain no counter and wait indefinitely.

Structure
REQ-029 SHALL place the state enum, TAG_W=11, and AXI_RESP_OKAY/SLVERR/DECERR constants in package iob_pkg.
REQ-030 SHALL use the single sub-module iob_arbiter for the IDLE-state grant logic; the rest SHALL be flat.

Verification
REQ-031 Fetch 0x00000006 with zero-wait slave returning rdata=0x00000013: araddr=0x00000004; i__core_val 3 cycles after accept; i__core_rdata=0x00000013, i__core_pc=0x00000004, error=0.
REQ-032 Data write addr=0x92000000, wdata=0xA5, wen=4'b0001, tag=0x155, awready 2 cycles after wready: wstrb=4'b0001; one d__core_val pulse with tag 0x155, rdata=0.
REQ-033 Simultaneous data read and fetch: data granted first; i__core_accept=0 until IDLE again; both complete in order.
REQ-034 Read with rresp=2'b10: d__core_error=1.
REQ-035 rst_n=0 in RD_DATA: the next cycle has all valids 0 and the state IDLE; no val pulse occurs.
REQ-036 With IOB_TIMEOUT_EN, arready held 0: an error response after 256 cycles.
